d_cache: RTL
============

// Module: d_cache
// PURPOSE
//  Responder side of the memory-stage <-> data-cache interface: direct-mapped, write-through,
//  no-write-allocate L1 data cache. Accepts read/write requests from the memory pipeline stage
//  (address, write data, write enable), returns read data with a valid strobe, and refills
//  lines / forwards writes over a req/ack word interface to the backing memory.
// PARAMETERS
//  LINES          64  number of cache lines (power of 2)
//  WORDS_PER_LINE 4   32-bit words per line (power of 2, >=2)
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_i        in   1   synchronous active-high reset
//  rd_i         in   1   read request from memory stage; held until valid_o
//  wr_i         in   1   write request from memory stage; held until valid_o
//  inv_i        in   1   invalidate all lines (honoured only in IDLE)
//  addr_i       in   32  byte address; bits [1:0] ignored
//  data_i       in   32  write data
//  data_o       out  32  read data; 0 whenever valid_o=0
//  valid_o      out  1   request complete this cycle (read data valid / write accepted)
//  mem_rd_o     out  1   memory word read request, held until mem_ack_i
//  mem_wr_o     out  1   memory word write request, held until mem_ack_i
//  mem_addr_o   out  32  memory word address (bits [1:0]=0)
//  mem_wdata_o  out  32  memory write data
//  mem_rdata_i  in   32  memory read data, valid with mem_ack_i
//  mem_ack_i    in   1   memory completion strobe
// BEHAVIOUR
//  - Address split: [1:0] byte, next log2(WPL) word, next log2(LINES) index, rest tag.
//  - Storage: flop arrays for data, tag, valid bit per line. Reset clears all valid bits and
//    all outputs to 0, FSM to IDLE; data/tag arrays not reset.
//  - FSM states IDLE, FILL, WRITE.
//  - IDLE priority: inv_i > wr_i > rd_i. inv_i: clear all valid bits at edge, valid_o=0.
//  - IDLE read hit: valid_o=1 and data_o=word combinationally, same cycle (0 added latency).
//  - IDLE read miss: valid_o=0; -> FILL, word counter=0.
//  - FILL: mem_rd_o=1, mem_addr_o={req tag,index,word_cnt,2'b00}; on mem_ack_i store
//    mem_rdata_i to word_cnt, word_cnt++ ; after ack of word WPL-1 write tag, set valid,
//    -> IDLE; held request hits next cycle. Miss latency = 2 + sum of memory ack latencies.
//  - IDLE write: -> WRITE, valid_o=0. WRITE: mem_wr_o=1, mem_addr_o={addr_i[31:2],2'b00},
//    mem_wdata_o=data_i; on mem_ack_i valid_o=1 same cycle, if line hit update word at that
//    edge, -> IDLE. Write miss does not allocate.
//  - Requester drops/changes request in the cycle after valid_o=1; request change while
//    valid_o=0 is a protocol violation (undefined result).
//  - rd_i and wr_i both high: treated as write.
//  - mem_ack_i outside FILL/WRITE ignored; inv_i outside IDLE ignored.
//  - mem_rd_o and mem_wr_o never both 1; both drop in the cycle after their final ack.
//  - rst_i mid-FILL/WRITE: at the edge return to IDLE, outputs 0, partially filled line
//    stays invalid; in-flight memory ack after reset ignored.
// TESTING (LINES=64, WPL=4: 1 KB, 16 B lines; memory model acks 1 cycle after request)
//  1. rd 0x100 after reset -> mem_rd_o at 0x100,0x104,0x108,0x10C, returns A0..A3;
//     valid_o=1 data_o=A0 cycle after last ack; then rd 0x108 -> same-cycle valid_o, A2.
//  2. wr 0x104=DEADBEEF (hit) with ack delayed 3 cycles -> mem_wr_o addr 0x104 data
//     DEADBEEF held 3 cycles, valid_o pulse on ack; rd 0x104 -> hit, DEADBEEF, no mem_rd_o.
//  3. wr 0x2000 (miss) -> one mem_wr_o only; rd 0x2000 afterwards -> miss, 4-word fill.
//  4. rd 0x100 then rd 0x500 (same index) -> eviction fill; rd 0x100 -> misses again.
//  5. rst_i after 2nd fill ack for 0x100 -> mem_rd_o=0 next cycle, valid_o=0; rd 0x100 -> full miss.
//  6. inv_i in IDLE after 0x100 filled -> rd 0x100 misses; inv_i during FILL -> no effect.

Source files
------------

// File: rtl/d_cache.sv
// Direct-mapped write-through, no-write-allocate L1 data cache. Read hits complete in the request cycle; misses fill a whole line.
// The requester is held (valid_o low) for the whole fill or write; each memory word request is held until mem_ack_i.
module d_cache #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic        inv_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TB = 30 - WB - IB;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]        state;
    logic [WB-1:0]     word_cnt;
    logic [LINES-1:0]  line_vld;
    logic [TB-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES][WORDS_PER_LINE];

    logic [WB-1:0]     req_word;
    logic [IB-1:0]     req_idx;
    logic [TB-1:0]     req_tag;
    logic              hit;
    logic              last_word;
    logic              unused_byte_bits;

    assign req_word         = addr_i[WB+1:2];
    assign req_idx          = addr_i[WB+IB+1:WB+2];
    assign req_tag          = addr_i[31:WB+IB+2];
    assign hit              = line_vld[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_word        = (word_cnt == WB'(WORDS_PER_LINE - 1));
    assign unused_byte_bits = ^addr_i[1:0];

    always_comb begin
        valid_o     = 1'b0;
        data_o      = '0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            ST_IDLE: begin
                // Read hit answers combinationally; a simultaneous write takes precedence.
                if (!inv_i && rd_i && !wr_i && hit) begin
                    valid_o = 1'b1;
                    data_o  = data_mem[req_idx][req_word];
                end
            end
            ST_FILL: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = {req_tag, req_idx, word_cnt, 2'b00};
            end
            ST_WRITE: begin
                mem_wr_o    = 1'b1;
                mem_addr_o  = {addr_i[31:2], 2'b00};
                mem_wdata_o = data_i;
                valid_o     = mem_ack_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            line_vld <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inv_i) begin
                        line_vld <= '0;
                    end else if (wr_i) begin
                        state <= ST_WRITE;
                    end else if (rd_i && !hit) begin
                        // The victim line is dropped up front so a partial fill is never visible.
                        state             <= ST_FILL;
                        word_cnt          <= '0;
                        line_vld[req_idx] <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (mem_ack_i) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            line_vld[req_idx] <= 1'b1;
                            state             <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == ST_FILL && mem_ack_i) begin
                data_mem[req_idx][word_cnt] <= mem_rdata_i;
                if (last_word) begin
                    tag_mem[req_idx] <= req_tag;
                end
            end
            if (state == ST_WRITE && mem_ack_i && hit) begin
                data_mem[req_idx][req_word] <= data_i;
            end
        end
    end

endmodule
